// File: rtl/uart_transmitter_pkg.sv
// uart_transmitter_pkg: FSM states and line levels shared by the UART transmitter and receiver
package uart_transmitter_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  function automatic logic parity_of(input logic [UART_DATA_BITS-1:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if: byte handshake between a data source and the UART transmitter
interface uart_transmitter_if;
  logic [uart_transmitter_pkg::UART_DATA_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_transmitter_tx_baud_tick.sv
// tx_baud_tick: counts clk cycles within a serial bit and flags the last cycle of each bit
module tx_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_end
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] cnt;
  assign bit_end = enable && cnt == W'(CLKS_PER_BIT - 1);
  // baud counter: restarts on accept, wraps at the end of each bit, rests at zero while idle
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear || bit_end || !enable) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one byte per handshake into start, 8 data LSB-first, parity, stop
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic clk,
  input  logic rst,
  uart_transmitter_if.slave tx,
  output logic serial_out,
  output logic busy
);
  uart_state_e state_q, state_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0] idx_q, idx_d;
  logic par_q, par_d, line_d, bit_end, accept;
  assign tx.tx_ready = state_q == IDLE || (state_q == STOP && bit_end);
  assign accept = tx.tx_valid && tx.tx_ready;
  assign busy = state_q != IDLE;
  tx_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst(rst),
    .clear(accept),
    .enable(busy),
    .bit_end(bit_end)
  );
  // state, datapath and line registers; reset forces the line idle without waiting for clk
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q <= '0;
      par_q <= 1'b0;
      serial_out <= UART_IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q <= idx_d;
      par_q <= par_d;
      serial_out <= line_d;
    end
  // next state: accept loads the byte and its parity, each bit_end advances the frame
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d = idx_q;
    par_d = par_q;
    if (accept) begin
      state_d = START;
      shreg_d = tx.tx_data;
      par_d = parity_of(tx.tx_data, PARITY_ODD);
    end else if (bit_end) begin
      state_d = state_q == START ? DATA :
                state_q == DATA ? (idx_q == 3'd7 ? PARITY : DATA) :
                state_q == PARITY ? STOP : IDLE;
      idx_d = state_q == DATA ? idx_q + 3'd1 : 3'd0;
      shreg_d = state_q == DATA ? shreg_q >> 1 : shreg_q;
    end
  end
  // line level for the state being entered, so the registered output lines up with the state
  always_comb
    line_d = state_d == START ? START_BIT :
             state_d == DATA ? shreg_d[0] :
             state_d == PARITY ? par_d :
             state_d == STOP ? STOP_BIT : UART_IDLE_LEVEL;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: scoreboard bench; a line monitor decodes frames and checks them against queued expectations
module tb_uart_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic so0, so1, busy0, busy1;
  int checks = 0;
  int errors = 0;
  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int n, w;
  logic [7:0] rb;

  uart_transmitter_if ifc0();
  uart_transmitter_if ifc1();

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tx(ifc0.slave), .serial_out(so0), .busy(busy0)
  );
  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tx(ifc1.slave), .serial_out(so1), .busy(busy1)
  );

  always #5 clk = ~clk;

  function automatic logic line(input int k);
    return k == 1 ? so1 : so0;
  endfunction

  function automatic logic rdy(input int k);
    return k == 1 ? ifc1.tx_ready : ifc0.tx_ready;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int c);
    repeat (c) @(negedge clk);
  endtask

  // frame e is {stop, parity, data[7:0], start}, bit 0 first on the line
  task automatic send(input int k, input logic [7:0] b, input logic [10:0] e);
    int t = 0;
    @(negedge clk);
    if (k == 1) begin ifc1.tx_valid = 1'b1; ifc1.tx_data = b; end
    else begin ifc0.tx_valid = 1'b1; ifc0.tx_data = b; end
    while (!rdy(k) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL send%0d timeout waiting for tx_ready", k);
    end else begin
      if (k == 1) q1.push_back(e); else q0.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon(input int k);
    logic [10:0] got, exp;
    logic stable, abort;
    forever begin
      @(negedge clk);
      if (rst && line(k) == 1'b0) begin
        got = '0; stable = 1'b1; abort = 1'b0;
        for (int b = 0; b < 11; b++)
          for (int c = 0; c < 4; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst) abort = 1'b1;
            if (c == 0) got[b] = line(k);
            else if (line(k) !== got[b]) stable = 1'b0;
          end
        if (abort) begin
          if (k == 1 && q1.size() > 0) void'(q1.pop_front());
          if (k == 0 && q0.size() > 0) void'(q0.pop_front());
        end else begin
          checks++;
          if ((k == 1 ? q1.size() : q0.size()) == 0) begin
            errors++;
            $display("FAIL frame%0d unexpected frame %b", k, got);
          end else begin
            exp = k == 1 ? q1.pop_front() : q0.pop_front();
            if (got !== exp || !stable) begin
              errors++;
              $display("FAIL frame%0d got %b expected %b bit_timing_ok %0b", k, got, exp, stable);
            end
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    ifc0.tx_valid = 1'b0; ifc0.tx_data = '0;
    ifc1.tx_valid = 1'b0; ifc1.tx_data = '0;
    cyc(3);
    chk("reset_line", so0, 1);
    chk("reset_ready", ifc0.tx_ready, 1);
    chk("reset_busy", busy0, 0);
    rst = 1'b1;
    cyc(1);
    chk("post_reset_line", so0, 1);
    chk("post_reset_ready", ifc0.tx_ready, 1);
    chk("post_reset_busy", busy0, 0);
    n = 0;
    repeat (100) begin @(negedge clk); if (so0 !== 1'b1) n++; end
    chk("idle_line_lows", n, 0);

    send(0, 8'hA5, 11'b1_0_10100101_0);
    ifc0.tx_valid = 1'b0;
    @(negedge clk);
    chk("start_latency", so0, 0);
    n = 0;
    while (!ifc0.tx_ready && n < 100) begin n++; @(negedge clk); end
    chk("ready_low_cycles", n, 43);
    cyc(10);

    send(1, 8'h00, 11'b1_1_00000000_0);
    send(1, 8'h01, 11'b1_0_00000001_0);
    send(1, 8'hFF, 11'b1_1_11111111_0);
    ifc1.tx_valid = 1'b0;
    cyc(60);

    fork
      begin
        send(0, 8'h55, 11'b1_0_01010101_0);
        send(0, 8'h0F, 11'b1_0_00001111_0);
        ifc0.tx_valid = 1'b0;
      end
      begin
        n = 0; w = 0;
        while (!busy0 && w < 100) begin @(negedge clk); w++; end
        while (busy0 && n < 300) begin n++; @(negedge clk); end
        chk("b2b_busy_cycles", n, 88);
      end
    join
    cyc(10);

    send(0, 8'h96, 11'b1_0_10010110_0);
    ifc0.tx_valid = 1'b0;
    cyc(18);
    chk("mid_frame_busy", busy0, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_line", so0, 1);
    chk("abort_busy", busy0, 0);
    #4 rst = 1'b1;
    cyc(60);
    send(0, 8'h3C, 11'b1_0_00111100_0);
    ifc0.tx_valid = 1'b0;
    cyc(60);

    for (int i = 0; i < 256; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(0, rb, {1'b1, ^rb, rb, 1'b0});
    end
    ifc0.tx_valid = 1'b0;
    cyc(60);
    chk("pending_frames0", q0.size(), 0);
    chk("pending_frames1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
